// File: rtl/sdram_client_arbiter_pkg.sv
// Shared widths, FSM state encoding and client identifiers for the two-client SDRAM front end.
package sdram_client_arbiter_pkg;

    localparam int SDRAM_ADDR_W = 24;
    localparam int SDRAM_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    typedef enum logic {
        CLIENT_A = 1'b0,
        CLIENT_B = 1'b1
    } client_t;

    function automatic client_t other_client(input client_t c);
        return (c == CLIENT_A) ? CLIENT_B : CLIENT_A;
    endfunction

endpackage

// File: rtl/sdram_client_arbiter_rr_arb2.sv
// Two-way grant selection: round-robin on ties when RR_ENABLE, otherwise client A always wins ties.
module sdram_rr_arb2
    import sdram_client_arbiter_pkg::*;
#(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    a_req,
    input  logic    b_req,
    input  logic    update,
    input  client_t granted,
    output client_t pick,
    output logic    any_req
);

    client_t last_grant;

    // Starting from B lets A win the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= CLIENT_B;
        end else if (update) begin
            last_grant <= granted;
        end
    end

    always_comb begin
        pick = CLIENT_A;
        if (a_req && b_req) begin
            pick = RR_ENABLE ? other_client(last_grant) : CLIENT_A;
        end else if (b_req) begin
            pick = CLIENT_B;
        end
    end

    assign any_req = a_req | b_req;

endmodule

// File: rtl/sdram_client_arbiter.sv
// Two-client front end for sdram_controller3: arbitrates, issues one transaction at a time,
// waits for the controller's completion edge (or a timeout) and returns the result to the winner.
module sdram_client_arbiter
    import sdram_client_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit RR_ENABLE      = 1'b1
) (
    input  logic                    CLOCK_50,
    input  logic                    rst,
    input  logic                    a_req,
    input  logic                    a_we,
    input  logic [SDRAM_ADDR_W-1:0] a_addr,
    input  logic [SDRAM_DATA_W-1:0] a_wdata,
    output logic                    a_ack,
    output logic [SDRAM_DATA_W-1:0] a_rdata,
    input  logic                    b_req,
    input  logic                    b_we,
    input  logic [SDRAM_ADDR_W-1:0] b_addr,
    input  logic [SDRAM_DATA_W-1:0] b_wdata,
    output logic                    b_ack,
    output logic [SDRAM_DATA_W-1:0] b_rdata,
    output logic [SDRAM_ADDR_W-1:0] address,
    output logic                    req_read,
    output logic                    req_write,
    output logic [SDRAM_DATA_W-1:0] data_in,
    input  logic [SDRAM_DATA_W-1:0] data_out,
    input  logic                    data_valid,
    input  logic                    write_complete,
    output logic                    timeout_err
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_t                  state;
    state_t                  state_next;
    client_t                 grant;
    client_t                 pick;
    logic                    any_req;
    logic                    op;
    logic [7:0]              timer;
    logic                    dv_q;
    logic                    wc_q;
    logic                    dv_rise;
    logic                    wc_rise;
    logic                    done_ok;
    logic                    done_timeout;
    logic                    sel_we;
    logic [SDRAM_ADDR_W-1:0] sel_addr;
    logic [SDRAM_DATA_W-1:0] sel_wdata;
    logic [SDRAM_DATA_W-1:0] result;

    sdram_rr_arb2 #(
        .RR_ENABLE(RR_ENABLE)
    ) u_arb (
        .clk    (CLOCK_50),
        .rst    (rst),
        .a_req  (a_req),
        .b_req  (b_req),
        .update (state == ST_ACK),
        .granted(grant),
        .pick   (pick),
        .any_req(any_req)
    );

    assign dv_rise = data_valid & ~dv_q;
    assign wc_rise = write_complete & ~wc_q;

    // Only the edge matching the latched operation counts; the other type is ignored.
    assign done_ok      = op ? wc_rise : dv_rise;
    assign done_timeout = !done_ok && ((timer + 8'd1) == TIMEOUT_LIM);
    assign result       = (done_ok && !op) ? data_out : '0;

    assign sel_we    = (pick == CLIENT_B) ? b_we    : a_we;
    assign sel_addr  = (pick == CLIENT_B) ? b_addr  : a_addr;
    assign sel_wdata = (pick == CLIENT_B) ? b_wdata : a_wdata;

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state <= ST_DRAIN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (any_req) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT:  if (done_ok || done_timeout) state_next = ST_ACK;
            ST_ACK:   state_next = ST_DRAIN;
            // Wait out any lingering completion level so it cannot complete the next transaction.
            ST_DRAIN: if (!data_valid && !write_complete) state_next = ST_IDLE;
            default:  state_next = ST_DRAIN;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            dv_q        <= 1'b0;
            wc_q        <= 1'b0;
            grant       <= CLIENT_A;
            op          <= 1'b0;
            timer       <= '0;
            address     <= '0;
            data_in     <= '0;
            req_read    <= 1'b0;
            req_write   <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            dv_q      <= data_valid;
            wc_q      <= write_complete;
            req_read  <= 1'b0;
            req_write <= 1'b0;
            a_ack     <= 1'b0;
            b_ack     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant     <= pick;
                        op        <= sel_we;
                        address   <= sel_addr;
                        data_in   <= sel_wdata;
                        req_read  <= ~sel_we;
                        req_write <= sel_we;
                    end
                end
                ST_ISSUE: begin
                    timer <= '0;
                end
                ST_WAIT: begin
                    timer <= timer + 8'd1;
                    if (done_ok || done_timeout) begin
                        if (grant == CLIENT_B) begin
                            b_ack   <= 1'b1;
                            b_rdata <= result;
                        end else begin
                            a_ack   <= 1'b1;
                            a_rdata <= result;
                        end
                        if (done_timeout) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_client_arbiter.sv
// Directed bench: two arbiter instances (round-robin and fixed priority) each behind a small controller stub.
module tb_sdram_client_arbiter;

    logic        clk;
    logic        rst;
    logic        a_req, a_we, b_req, b_we;
    logic [23:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;

    logic        a_ack1, b_ack1, rr1, rw1, dv1, wc1, terr1;
    logic [31:0] a_rdata1, b_rdata1, din1, dout1;
    logic [23:0] addr1;
    logic        a_ack2, b_ack2, rr2, rw2, dv2, wc2, terr2;
    logic [31:0] a_rdata2, b_rdata2, din2, dout2;
    logic [23:0] addr2;

    int checks;
    int errors;
    int resp_en, resp_lat, resp_hold;
    int stray_req, stray_done;
    int rr_cnt, rw_cnt, acka_cnt, ackb_cnt, both_cnt;

    logic [31:0] mem1 [16];
    logic [31:0] mem2 [16];
    logic        is_rd1, is_rd2;
    logic [23:0] cap_a1, cap_a2;
    logic [31:0] cap_d1, cap_d2;

    sdram_client_arbiter #(.TIMEOUT_CYCLES(16), .RR_ENABLE(1'b1)) dut1 (
        .CLOCK_50(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack1), .a_rdata(a_rdata1),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack1), .b_rdata(b_rdata1),
        .address(addr1), .req_read(rr1), .req_write(rw1), .data_in(din1), .data_out(dout1),
        .data_valid(dv1), .write_complete(wc1), .timeout_err(terr1)
    );

    sdram_client_arbiter #(.TIMEOUT_CYCLES(16), .RR_ENABLE(1'b0)) dut2 (
        .CLOCK_50(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack2), .a_rdata(a_rdata2),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack2), .b_rdata(b_rdata2),
        .address(addr2), .req_read(rr2), .req_write(rw2), .data_in(din2), .data_out(dout2),
        .data_valid(dv2), .write_complete(wc2), .timeout_err(terr2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Controller stub for dut1: fixed latency, configurable level hold, optional stray write_complete.
    initial begin
        dv1 = 0; wc1 = 0; dout1 = 0; stray_done = 0;
        for (int i = 0; i < 16; i++) mem1[i] = 32'hC0DE_0000 + i;
        forever begin
            @(negedge clk);
            if (stray_req != stray_done) begin
                wc1 = 1;
                @(negedge clk);
                wc1 = 0;
                stray_done++;
            end else if (resp_en != 0 && (rr1 || rw1)) begin
                is_rd1 = rr1; cap_a1 = addr1; cap_d1 = din1;
                repeat (resp_lat) @(negedge clk);
                if (is_rd1) begin dout1 = mem1[cap_a1[3:0]]; dv1 = 1; end
                else begin mem1[cap_a1[3:0]] = cap_d1; wc1 = 1; end
                repeat (resp_hold) @(negedge clk);
                dv1 = 0; wc1 = 0;
            end
        end
    end

    initial begin
        dv2 = 0; wc2 = 0; dout2 = 0;
        for (int i = 0; i < 16; i++) mem2[i] = 32'hC0DE_0000 + i;
        forever begin
            @(negedge clk);
            if (resp_en != 0 && (rr2 || rw2)) begin
                is_rd2 = rr2; cap_a2 = addr2; cap_d2 = din2;
                repeat (resp_lat) @(negedge clk);
                if (is_rd2) begin dout2 = mem2[cap_a2[3:0]]; dv2 = 1; end
                else begin mem2[cap_a2[3:0]] = cap_d2; wc2 = 1; end
                repeat (resp_hold) @(negedge clk);
                dv2 = 0; wc2 = 0;
            end
        end
    end

    initial begin
        rr_cnt = 0; rw_cnt = 0; acka_cnt = 0; ackb_cnt = 0; both_cnt = 0;
        forever begin
            @(negedge clk);
            if (rr1) rr_cnt++;
            if (rw1) rw_cnt++;
            if (a_ack1) acka_cnt++;
            if (b_ack1) ackb_cnt++;
            if (a_ack1 && b_ack1) both_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Raise one client's request at a negedge; return negedges until dut1 acks it (-1 if none).
    task automatic txn(input logic is_b, input logic we, input logic [23:0] addr,
                       input logic [31:0] wd, output int n);
        if (is_b) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
        else begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
        n = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if ((is_b ? b_ack1 : a_ack1) === 1'b1) begin
                n = i;
                break;
            end
        end
        a_req = 0;
        b_req = 0;
    endtask

    task automatic pulse_rst();
        rst = 1;
        @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int base_rr, base_rw, base_a, base_b, cnt_a, cnt_b;
        int glog [4];
        checks = 0; errors = 0;
        resp_en = 1; resp_lat = 2; resp_hold = 1; stray_req = 0;
        rst = 1;
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        repeat (3) @(negedge clk);
        check("rst_acks", {30'd0, a_ack1, b_ack1}, 0);
        check("rst_reqs", {30'd0, rr1, rw1}, 0);
        check("rst_address", {8'd0, addr1}, 0);
        check("rst_data_in", din1, 0);
        check("rst_a_rdata", a_rdata1, 0);
        check("rst_timeout_err", {31'd0, terr1}, 0);
        rst = 0;
        repeat (3) @(negedge clk);

        // Write then read back through client A.
        base_rr = rr_cnt; base_rw = rw_cnt;
        txn(1'b0, 1'b1, 24'h000123, 32'hDEADBEEF, n);
        check("t1_write_lat", n, 4);
        repeat (3) @(negedge clk);
        check("t1_write_pulse", rw_cnt - base_rw, 1);
        check("t1_no_read_pulse", rr_cnt - base_rr, 0);
        txn(1'b0, 1'b0, 24'h000123, 32'h0, n);
        check("t1_read_lat", n, 4);
        check("t1_read_data", a_rdata1, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        check("t1_read_pulse", rr_cnt - base_rr, 1);

        // Both clients requesting continuously: strict alternation starting with A.
        pulse_rst();
        base_rr = rr_cnt;
        a_req = 1; a_we = 0; a_addr = 24'h000003;
        b_req = 1; b_we = 0; b_addr = 24'h000007;
        n = 0;
        for (int i = 0; i < 4; i++) glog[i] = -1;
        for (int i = 0; i < 200 && n < 4; i++) begin
            @(negedge clk);
            if (a_ack1) begin glog[n] = 0; n++; end
            else if (b_ack1) begin glog[n] = 1; n++; end
        end
        a_req = 0; b_req = 0;
        repeat (5) @(negedge clk);
        check("t2_grant0", glog[0], 0);
        check("t2_grant1", glog[1], 1);
        check("t2_grant2", glog[2], 0);
        check("t2_grant3", glog[3], 1);
        check("t2_no_dual_ack", both_cnt, 0);
        check("t2_reads", rr_cnt - base_rr, 4);
        check("t2_a_rdata", a_rdata1, 32'hDEADBEEF);
        check("t2_b_rdata", b_rdata1, 32'hC0DE0007);

        // data_valid held 3 cycles: one ack, and B waits for the level to fall.
        resp_hold = 3;
        base_a = acka_cnt; base_b = ackb_cnt;
        txn(1'b0, 1'b0, 24'h000003, 32'h0, n);
        check("t3_a_lat", n, 4);
        txn(1'b1, 1'b0, 24'h000007, 32'h0, n);
        check("t3_b_lat_after_drain", n, 7);
        resp_hold = 1;
        repeat (10) @(negedge clk);
        check("t3_a_ack_count", acka_cnt - base_a, 1);
        check("t3_b_ack_count", ackb_cnt - base_b, 1);

        // Controller never answers: timeout after 16 WAIT cycles.
        resp_en = 0;
        txn(1'b0, 1'b0, 24'h000003, 32'h0, n);
        check("t4_timeout_lat", n, 18);
        check("t4_rdata_zero", a_rdata1, 0);
        check("t4_timeout_err", {31'd0, terr1}, 1);
        repeat (20) @(negedge clk);
        check("t4_timeout_sticky", {31'd0, terr1}, 1);
        resp_en = 1;

        // Reset while waiting on a slow write; the late completion and a stray pulse are ignored.
        resp_lat = 10;
        base_a = acka_cnt; base_b = ackb_cnt;
        a_req = 1; a_we = 1; a_addr = 24'h000005; a_wdata = 32'h12345678;
        repeat (4) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0; a_req = 0;
        check("t5_acks", {30'd0, a_ack1, b_ack1}, 0);
        check("t5_b_rdata", b_rdata1, 0);
        check("t5_address", {8'd0, addr1}, 0);
        check("t5_data_in", din1, 0);
        check("t5_timeout_err", {31'd0, terr1}, 0);
        repeat (15) @(negedge clk);
        stray_req++;
        repeat (6) @(negedge clk);
        check("t5_no_ack", (acka_cnt - base_a) + (ackb_cnt - base_b), 0);
        resp_lat = 2;
        txn(1'b0, 1'b0, 24'h000005, 32'h0, n);
        check("t5_idle_read_lat", n, 4);
        check("t5_late_write_data", a_rdata1, 32'h12345678);

        // Fixed priority instance: A wins every time while both request.
        repeat (3) @(negedge clk);
        pulse_rst();
        a_req = 1; a_we = 0; a_addr = 24'h000003;
        b_req = 1; b_we = 0; b_addr = 24'h000007;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 300 && cnt_a < 4; i++) begin
            @(negedge clk);
            if (a_ack2) cnt_a++;
            if (b_ack2) cnt_b++;
        end
        a_req = 0; b_req = 0;
        check("t6_a_acks", cnt_a, 4);
        check("t6_b_never", cnt_b, 0);
        check("t6_a_rdata", a_rdata2, 32'hDEADBEEF);
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
